// File: rtl/tmboc_corr_accum_if.sv
// Bus bundle for the TMBOC early/prompt/late correlator.
//
// Carries the baseband samples, local code, PRN epoch markers, integration
// length and dump handshake into the correlator, and the six dumped sums plus
// the valid/overflow flags back out.
//
//   master : sample/code producer and dump consumer (drives rx_*)
//   slave  : the correlator itself (drives tx_*)
interface tmboc_corr_accum_if #(
   parameter int IQ_WIDTH  = 4,
   parameter int ACC_WIDTH = 24
);
   logic                        rx_corr_en;
   logic signed [IQ_WIDTH-1:0]  rx_i_data;
   logic signed [IQ_WIDTH-1:0]  rx_q_data;
   logic                        rx_loc_code;
   logic                        rx_prn_sop;
   logic                        rx_prn_eop;
   logic [4:0]                  rx_int_epochs;
   logic                        rx_dump_ack;
   logic signed [ACC_WIDTH-1:0] tx_ie;
   logic signed [ACC_WIDTH-1:0] tx_qe;
   logic signed [ACC_WIDTH-1:0] tx_ip;
   logic signed [ACC_WIDTH-1:0] tx_qp;
   logic signed [ACC_WIDTH-1:0] tx_il;
   logic signed [ACC_WIDTH-1:0] tx_ql;
   logic                        tx_dump_vld;
   logic                        tx_ovf;

   modport master (
      output rx_corr_en, rx_i_data, rx_q_data, rx_loc_code,
             rx_prn_sop, rx_prn_eop, rx_int_epochs, rx_dump_ack,
      input  tx_ie, tx_qe, tx_ip, tx_qp, tx_il, tx_ql, tx_dump_vld, tx_ovf
   );

   modport slave (
      input  rx_corr_en, rx_i_data, rx_q_data, rx_loc_code,
             rx_prn_sop, rx_prn_eop, rx_int_epochs, rx_dump_ack,
      output tx_ie, tx_qe, tx_ip, tx_qp, tx_il, tx_ql, tx_dump_vld, tx_ovf
   );
endinterface

// File: rtl/tmboc_corr_accum.sv
// Early/prompt/late correlator with integrate-and-dump for the B1 TMBOC
// tracking channel.
//
// Ports:
//   rx_clk    single clock, one sample per cycle
//   rx_rst_n  asynchronous active-low reset
//   bus       tmboc_corr_accum_if.slave: samples, code, epoch markers,
//             integration length, dump handshake and the six dumped sums
//
// Build option: define TMBOC_CORR_SAT_EN to make accumulation and the dump
// sum saturate instead of wrapping. Port list is the same either way.
//
// Pipeline: code taps c[0]/c[D]/c[2D] and the D+1 deep data/marker delay
// line feed a registered product stage; accumulation runs one cycle after
// that, so a DUMP lands D+2 edges after the triggering eop is sampled.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | accumulators held at 0, waiting for an aligned sop with enable
// ST_INTEG | accumulating every sample; dump when the Nth eop arrives
module tmboc_corr_accum #(
   parameter int IQ_WIDTH    = 4,
   parameter int ACC_WIDTH   = 24,
   parameter int EPL_SPACING = 2
) (
   input  logic               rx_clk,
   input  logic               rx_rst_n,
   tmboc_corr_accum_if.slave  bus
);
   localparam int D  = EPL_SPACING;
   localparam int PW = IQ_WIDTH + 1;

   typedef enum logic {ST_IDLE, ST_INTEG} state_t;

   state_t                      state_q, state_d;
   logic [2*D:0]                code_q;
   logic [D:0][IQ_WIDTH-1:0]    i_dl_q, q_dl_q;
   logic [D:0]                  sop_dl_q, eop_dl_q;
   logic                        sop_p_q, eop_p_q;
   logic signed [PW-1:0]        prod_q [6];
   logic signed [ACC_WIDTH-1:0] acc_q [6], acc_d [6];
   logic signed [ACC_WIDTH-1:0] out_q [6], out_d [6];
   logic signed [ACC_WIDTH-1:0] sum_c [6];
   logic [4:0]                  cnt_q, cnt_d;
   logic [4:0]                  n_q, n_d;
   logic [4:0]                  n_in, n_eff;
   logic                        vld_q, vld_d;
   logic                        ovf_q, ovf_d;
   logic                        dump_c;
   logic signed [IQ_WIDTH-1:0]  i_a, q_a;

   assign i_a = $signed(i_dl_q[D]);
   assign q_a = $signed(q_dl_q[D]);

   // code bit 0 is +1, 1 is -1; widened first so that negating the most
   // negative sample cannot overflow
   function automatic logic signed [PW-1:0] apply_code(
      input logic signed [IQ_WIDTH-1:0] x, input logic c);
      logic signed [PW-1:0] xe;
      xe = {x[IQ_WIDTH-1], x};
      return c ? -xe : xe;
   endfunction

   function automatic logic signed [ACC_WIDTH-1:0] acc_add(
      input logic signed [ACC_WIDTH-1:0] a, input logic signed [PW-1:0] p);
`ifdef TMBOC_CORR_SAT_EN
      logic signed [ACC_WIDTH:0] s;
      s = (ACC_WIDTH+1)'(a) + (ACC_WIDTH+1)'(p);
      if (s[ACC_WIDTH] != s[ACC_WIDTH-1])
         return s[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                             : {1'b0, {(ACC_WIDTH-1){1'b1}}};
      return s[ACC_WIDTH-1:0];
`else
      return a + ACC_WIDTH'(p);
`endif
   endfunction

   // 0 epochs behaves as 1
   assign n_in  = (bus.rx_int_epochs == 5'd0) ? 5'd1 : bus.rx_int_epochs;
   // the epoch length is taken fresh on the sample that opens an integration
   assign n_eff = (state_q == ST_IDLE) ? n_in : n_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      n_d     = n_q;
      vld_d   = vld_q;
      ovf_d   = ovf_q;
      dump_c  = 1'b0;
      for (int k = 0; k < 6; k++) begin
         acc_d[k] = acc_q[k];
         out_d[k] = out_q[k];
         sum_c[k] = acc_add(acc_q[k], prod_q[k]);
      end

      if (!bus.rx_corr_en) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
         for (int k = 0; k < 6; k++) acc_d[k] = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (sop_p_q) begin
                  state_d = ST_INTEG;
                  n_d     = n_in;
                  dump_c  = eop_p_q && (cnt_q == n_eff - 5'd1);
               end
            end
            ST_INTEG: begin
               dump_c = eop_p_q && (cnt_q == n_eff - 5'd1);
            end
            default: state_d = ST_IDLE;
         endcase

         if (state_d == ST_INTEG) begin
            if (dump_c) begin
               cnt_d = '0;
               n_d   = n_in;
               for (int k = 0; k < 6; k++) begin
                  out_d[k] = sum_c[k];
                  acc_d[k] = '0;
               end
            end else begin
               if (eop_p_q) cnt_d = cnt_q + 5'd1;
               for (int k = 0; k < 6; k++) acc_d[k] = sum_c[k];
            end
         end
      end

      if (dump_c) begin
         vld_d = 1'b1;
         if (vld_q && !bus.rx_dump_ack) ovf_d = 1'b1;
      end else if (bus.rx_dump_ack) begin
         vld_d = 1'b0;
      end
   end

   always_ff @(posedge rx_clk or negedge rx_rst_n) begin
      if (!rx_rst_n) begin
         state_q  <= ST_IDLE;
         code_q   <= '0;
         i_dl_q   <= '0;
         q_dl_q   <= '0;
         sop_dl_q <= '0;
         eop_dl_q <= '0;
         sop_p_q  <= 1'b0;
         eop_p_q  <= 1'b0;
         cnt_q    <= '0;
         n_q      <= 5'd1;
         vld_q    <= 1'b0;
         ovf_q    <= 1'b0;
         for (int k = 0; k < 6; k++) begin
            prod_q[k] <= '0;
            acc_q[k]  <= '0;
            out_q[k]  <= '0;
         end
      end else begin
         state_q  <= state_d;
         code_q   <= {code_q[2*D-1:0], bus.rx_loc_code};
         i_dl_q   <= {i_dl_q[D-1:0], bus.rx_i_data};
         q_dl_q   <= {q_dl_q[D-1:0], bus.rx_q_data};
         sop_dl_q <= {sop_dl_q[D-1:0], bus.rx_prn_sop};
         eop_dl_q <= {eop_dl_q[D-1:0], bus.rx_prn_eop};
         sop_p_q  <= sop_dl_q[D];
         eop_p_q  <= eop_dl_q[D];
         prod_q[0] <= apply_code(i_a, code_q[0]);
         prod_q[1] <= apply_code(q_a, code_q[0]);
         prod_q[2] <= apply_code(i_a, code_q[D]);
         prod_q[3] <= apply_code(q_a, code_q[D]);
         prod_q[4] <= apply_code(i_a, code_q[2*D]);
         prod_q[5] <= apply_code(q_a, code_q[2*D]);
         cnt_q    <= cnt_d;
         n_q      <= n_d;
         vld_q    <= vld_d;
         ovf_q    <= ovf_d;
         for (int k = 0; k < 6; k++) begin
            acc_q[k] <= acc_d[k];
            out_q[k] <= out_d[k];
         end
      end
   end

   assign bus.tx_ie       = out_q[0];
   assign bus.tx_qe       = out_q[1];
   assign bus.tx_ip       = out_q[2];
   assign bus.tx_qp       = out_q[3];
   assign bus.tx_il       = out_q[4];
   assign bus.tx_ql       = out_q[5];
   assign bus.tx_dump_vld = vld_q;
   assign bus.tx_ovf      = ovf_q;
endmodule

// File: doc/tmboc_corr_accum.md
# tmboc_corr_accum

Early/prompt/late correlator and integrate-and-dump stage for the B1 TMBOC tracking channel. It consumes the local TMBOC chip stream and the PRN epoch markers (`sop`/`eop`) from the PRN tracking generator, together with carrier-wiped baseband I/Q samples. It produces coherent E/P/L I/Q sums once per programmable number of code epochs for the loop discriminators.

## Interface
Parameters:
- `IQ_WIDTH`, 4: signed width of the I and Q input samples.
- `ACC_WIDTH`, 24: signed width of each accumulator and dump output.
- `EPL_SPACING`, 2: E–P and P–L spacing in samples (D). Legal range 1..8.

Ports:
- `rx_clk`  in  1  single clock; one sample per cycle.
- `rx_rst_n`  in  1  asynchronous, active-low reset.
- `rx_corr_en`  in  1  correlator enable.
- `rx_i_data`, `rx_q_data`  in  IQ_WIDTH each  signed baseband samples.
- `rx_loc_code`  in  1  local TMBOC chip value; 0 maps to +1, 1 maps to −1.
- `rx_prn_sop`, `rx_prn_eop`  in  1 each  single-cycle epoch start/end markers, aligned with `rx_loc_code`.
- `rx_int_epochs`  in  5  epochs per dump; 0 is treated as 1.
- `rx_dump_ack`  in  1  consumer has taken the current dump.
- `tx_ie`, `tx_qe`, `tx_ip`, `tx_qp`, `tx_il`, `tx_ql`  out  ACC_WIDTH each  dumped sums.
- `tx_dump_vld`  out  1  dump registers hold unread data.
- `tx_ovf`  out  1  sticky flag: a dump was overwritten before it was acknowledged.

## Operation
- **Code delay line.** c[0..2D] holds the registered code. c[0] = `rx_loc_code` from the previous cycle; c[k] = c[k−1] delayed one more cycle.
- **Tap assignment.** Early = c[0], prompt = c[D], late = c[2D].
- **Marker alignment.** Data and the `sop`/`eop` markers are delayed D+1 registers, so they align with c[D] (prompt). The aligned markers are called sop_a and eop_a.
- **Products.** Six products: ±I and ±Q for each tap, with the sign set by the code bit. Each product is sign-extended to ACC_WIDTH and added into its accumulator.
- **State machine:**
  - IDLE: accumulators held at 0. Go to INTEG on a cycle with sop_a=1 and `rx_corr_en`=1; that sample is the first one accumulated.
  - INTEG: accumulate every cycle.
    - On eop_a, increment the epoch counter.
    - When eop_a coincides with epoch counter = N−1 (N is the latched `rx_int_epochs`, 0 treated as 1), perform a DUMP.
  - DUMP:
    - output registers ← acc + current product; accumulators ← 0; epoch counter ← 0.
    - Re-latch N from `rx_int_epochs`.
    - Stay in INTEG; the next sample starts a fresh sum.
- **Enable.** `rx_corr_en`=0 in any state:
  - Go to IDLE on the next edge; clear the accumulators and epoch counter.
  - Output registers, `tx_dump_vld` and `tx_ovf` are untouched.
  - A `rx_int_epochs` change mid-integration has no effect until the next dump.
- **Handshake:**
  - `tx_dump_vld` rises on the edge of a DUMP.
  - It falls on the first edge where `rx_dump_ack`=1 and no DUMP occurs.
  - DUMP with `tx_dump_vld`=1 and `rx_dump_ack`=0: outputs are overwritten, `tx_dump_vld` stays 1, and `tx_ovf` ← 1.
  - DUMP and `rx_dump_ack`=1 on the same edge: new data is loaded, `tx_dump_vld` stays 1, and `tx_ovf` is unchanged.
- **Overflow flag.** `tx_ovf` is cleared only by reset.
- **Accumulator arithmetic:** two's complement. Without the macro below, overflow wraps modulo 2^ACC_WIDTH.

## Timing
- Reset values: all outputs, accumulators, delay lines, epoch counter = 0; state IDLE; N latch = 1.
- Latency: an eop sample sampled at edge t that triggers a DUMP gives `tx_dump_vld`=1 and valid sums after edge t+D+2.
- Throughput: one sample per cycle, no stall. Back-to-back dumps are legal, minimum spacing 1 epoch.
- A sop_a arriving during INTEG is ignored; only the epoch count governs dumps.
- sop_a and eop_a in the same cycle (1-sample epoch, bench only): enter INTEG and process the eop on that sample.

## Configuration
- `TMBOC_CORR_SAT_EN` defined: each accumulator, and the final DUMP sum, saturates at +(2^(ACC_WIDTH−1)−1) / −2^(ACC_WIDTH−1).
- `TMBOC_CORR_SAT_EN` undefined: wrap-around arithmetic as stated above. The port list is identical in both builds.

## Test plan
Common bench setup: D=2, 10-sample epochs (sop at sample 0, eop at sample 9).

- **Basic dump.** I=+1, Q=0, code all 0, N=1. Expect:
  - `tx_ip`=`tx_ie`=`tx_il`=+10, Q outputs 0.
  - `tx_dump_vld` high D+2=4 cycles after the input eop.
- **Tap separation.** Code 1 for a single chip (sample 5), else 0; I=+1, N=1. Expect `tx_ie`=`tx_ip`=`tx_il`=8, with the negative sample landing at prompt timing, early 2 samples sooner and late 2 samples later. Check each tap against the aligned sample.
- **Multi-epoch integration.** Q=−2, code 0, N=3. Expect:
  - Exactly one dump per 30 samples, `tx_qp`=−60.
  - With `rx_int_epochs`=0: a dump every epoch.
- **Handshake and overflow.**
  - Hold `rx_dump_ack`=0 across two dumps: `tx_ovf`=1, outputs carry the second dump.
  - Ack coincident with a dump: `tx_dump_vld` stays 1, no `tx_ovf`.
- **Enable and async reset.**
  - Drop `rx_corr_en` mid-epoch, raise it later: no dump until a full period after the next sop_a, and the sum equals the full period.
  - Assert `rx_rst_n` low mid-cycle: all outputs go to 0 immediately.
- **Saturation.** ACC_WIDTH=8, I=+7, code 0, 20-sample epoch, N=1:
  - With `TMBOC_CORR_SAT_EN`: `tx_ip`=127.
  - Without: `tx_ip`=140−256=−116.
